// File: rtl/video_timing_pkg.sv
// Shared timing defaults and the per-axis phase encoding for the video timing generator.
package video_timing_pkg;

    localparam int CNT_W     = 9;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 256;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 32;
    localparam int DEF_H_BP     = 80;

    localparam int DEF_V_ACTIVE = 224;
    localparam int DEF_V_FP     = 16;
    localparam int DEF_V_SYNC   = 8;
    localparam int DEF_V_BP     = 16;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

endpackage

// File: rtl/video_axis_counter.sv
// One timing axis: position counter, terminal-count flag and ACTIVE/FRONT/SYNC/BACK phase FSM.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACT_LEN  = DEF_H_ACTIVE,
    parameter int FP_LEN   = DEF_H_FP,
    parameter int SYNC_LEN = DEF_H_SYNC,
    parameter int BP_LEN   = DEF_H_BP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output phase_t           phase
);

    localparam int TOTAL = ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN;

    localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACT_LEN);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACT_LEN + FP_LEN);
    localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACT_LEN + FP_LEN + SYNC_LEN);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);

    // Every phase must be non-empty so the FSM never has to skip a state in one step.
    generate
        if (TOTAL > MAX_TOTAL || ACT_LEN < 1 || FP_LEN < 1 || SYNC_LEN < 1 || BP_LEN < 1) begin : g_bad_timing
            $error("video_axis_counter: axis total exceeds 9-bit range or a phase length is zero");
        end
    endgenerate

    logic [CNT_W-1:0] count_reg, count_next;
    phase_t           phase_reg, phase_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            phase_reg <= ACTIVE;
        end else begin
            count_reg <= count_next;
            phase_reg <= phase_next;
        end
    end

    assign wrap = (count_reg == LAST);

    // The phase always describes count_reg, so transitions key off the value being loaded.
    always_comb begin
        count_next = count_reg;
        phase_next = phase_reg;
        if (en) begin
            count_next = wrap ? '0 : count_reg + CNT_W'(1);
            unique case (phase_reg)
                ACTIVE:  if (count_next == FP_START)   phase_next = FRONT;
                FRONT:   if (count_next == SYNC_START) phase_next = SYNC;
                SYNC:    if (count_next == BP_START)   phase_next = BACK;
                BACK:    if (wrap)                     phase_next = ACTIVE;
                default: phase_next = ACTIVE;
            endcase
        end
    end

    assign count = count_reg;
    assign phase = phase_reg;

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator with registered, blanked RGB and active-low syncs.
// Define CSYNC_SERRATION_EN to build csync as hsync_n XNOR vsync_n (serrated vertical sync).
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [11:0]      rgb_in,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             active,
    output logic             frame_start,
    output logic [3:0]       video_r,
    output logic [3:0]       video_g,
    output logic [3:0]       video_b,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             csync
);

    logic   h_wrap, v_wrap, v_en;
    phase_t h_phase, v_phase;

    assign v_en = ce_pix & h_wrap;

    video_axis_counter #(
        .ACT_LEN (H_ACTIVE),
        .FP_LEN  (H_FP),
        .SYNC_LEN(H_SYNC),
        .BP_LEN  (H_BP)
    ) u_h_axis (
        .clk  (clk),
        .reset(reset),
        .en   (ce_pix),
        .count(hcount),
        .wrap (h_wrap),
        .phase(h_phase)
    );

    video_axis_counter #(
        .ACT_LEN (V_ACTIVE),
        .FP_LEN  (V_FP),
        .SYNC_LEN(V_SYNC),
        .BP_LEN  (V_BP)
    ) u_v_axis (
        .clk  (clk),
        .reset(reset),
        .en   (v_en),
        .count(vcount),
        .wrap (v_wrap),
        .phase(v_phase)
    );

    assign active      = (h_phase == ACTIVE) && (v_phase == ACTIVE);
    assign frame_start = ce_pix & h_wrap & v_wrap & ~reset;

    logic [11:0] video_reg, video_next;
    logic        hsync_n_reg, hsync_n_next;
    logic        vsync_n_reg, vsync_n_next;
    logic        csync_reg, csync_next;

    always_comb begin
        video_next   = video_reg;
        hsync_n_next = hsync_n_reg;
        vsync_n_next = vsync_n_reg;
        if (ce_pix) begin
            video_next   = active ? rgb_in : 12'h000;
            hsync_n_next = (h_phase != SYNC);
            vsync_n_next = (v_phase != SYNC);
        end
    end

    // Derived from the next sync values so csync stays aligned with hsync_n/vsync_n.
`ifdef CSYNC_SERRATION_EN
    assign csync_next = ~(hsync_n_next ^ vsync_n_next);
`else
    assign csync_next = hsync_n_next & vsync_n_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            video_reg   <= '0;
            hsync_n_reg <= 1'b1;
            vsync_n_reg <= 1'b1;
            csync_reg   <= 1'b1;
        end else begin
            video_reg   <= video_next;
            hsync_n_reg <= hsync_n_next;
            vsync_n_reg <= vsync_n_next;
            csync_reg   <= csync_next;
        end
    end

    assign video_r = video_reg[11:8];
    assign video_g = video_reg[7:4];
    assign video_b = video_reg[3:0];
    assign hsync_n = hsync_n_reg;
    assign vsync_n = vsync_n_reg;
    assign csync   = csync_reg;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Self-checking bench for video_timing_ctrl: default horizontal timing, shortened vertical timing.
// Honours CSYNC_SERRATION_EN the same way the design does.
`timescale 1ns/1ps
module tb_video_timing_ctrl;

    localparam int HA = 256, HF = 16, HS = 32, HB = 80;
    localparam int HT = HA + HF + HS + HB;
    localparam int VA = 6, VF = 2, VS = 2, VB = 2;
    localparam int VT = VA + VF + VS + VB;
`ifdef CSYNC_SERRATION_EN
    localparam int CS_HI_EXP = 2 * HS;
`else
    localparam int CS_HI_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_pix = 1'b0;
    logic [11:0] rgb_in = 12'h000;
    logic [8:0]  hcount, vcount;
    logic        active, frame_start;
    logic [3:0]  video_r, video_g, video_b;
    logic        hsync_n, vsync_n, csync;

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .rgb_in(rgb_in),
        .hcount(hcount), .vcount(vcount), .active(active), .frame_start(frame_start),
        .video_r(video_r), .video_g(video_g), .video_b(video_b),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .csync(csync)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    endtask

    // Reference model: raster position plus the registered outputs from the last enabled pixel.
    int          mh = 0, mv = 0;
    logic [11:0] mvid = 12'h000;
    logic        mhs = 1'b1, mvs = 1'b1, mcs = 1'b1;
    bit          model_ok = 1'b0;

    function automatic bit in_band(input int p, input int lo, input int len);
        return (p >= lo) && (p < lo + len);
    endfunction

    function automatic logic model_csync(input logic hs_n, input logic vs_n);
`ifdef CSYNC_SERRATION_EN
        return ~(hs_n ^ vs_n);
`else
        return hs_n & vs_n;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mh <= 0; mv <= 0; mvid <= 12'h000;
            mhs <= 1'b1; mvs <= 1'b1; mcs <= 1'b1;
            model_ok <= 1'b1;
        end else if (ce_pix && model_ok) begin
            mvid <= (mh < HA && mv < VA) ? rgb_in : 12'h000;
            mhs  <= !in_band(mh, HA + HF, HS);
            mvs  <= !in_band(mv, VA + VF, VS);
            mcs  <= model_csync(!in_band(mh, HA + HF, HS), !in_band(mv, VA + VF, VS));
            mh   <= (mh == HT - 1) ? 0 : mh + 1;
            if (mh == HT - 1) mv <= (mv == VT - 1) ? 0 : mv + 1;
        end
    end

    logic [34:0] got_vec, exp_vec;
    logic        exp_fs;

    always @(negedge clk) begin
        if (model_ok) begin
            exp_fs  = ce_pix && !reset && (mh == HT - 1) && (mv == VT - 1);
            got_vec = {hcount, vcount, active, frame_start, video_r, video_g, video_b,
                       hsync_n, vsync_n, csync};
            exp_vec = {9'(mh), 9'(mv), (mh < HA && mv < VA), exp_fs, mvid, mhs, mvs, mcs};
            n_checks++;
            if (got_vec == exp_vec) n_pass++;
            else $display("FAIL model t=%0t: got h=%0d v=%0d act=%b fs=%b rgb=%h hs=%b vs=%b cs=%b, expected h=%0d v=%0d act=%b fs=%b rgb=%h hs=%b vs=%b cs=%b",
                          $time, hcount, vcount, active, frame_start, {video_r, video_g, video_b},
                          hsync_n, vsync_n, csync, mh, mv, exp_vec[15], exp_fs, mvid, mhs, mvs, mcs);
        end
    end

    // Inputs change just after the active edge; the caller samples on the following falling edge.
    task automatic step(input bit ce, input bit rst);
        @(posedge clk);
        #1;
        ce_pix = ce;
        reset  = rst;
        if (mh == 10 && mv == 5)       rgb_in = 12'hF0A;
        else if (mh == 300 && mv == 5) rgb_in = 12'hFFF;
        else                           rgb_in = 12'($urandom);
        @(negedge clk);
    endtask

    int fs_cnt = 0, fs_at = 0, hs_first = -1, hs_low = 0, vs_first = -1, vs_lines = 0, cs_hi = 0;
    bit seen_px = 1'b0, seen_blank = 1'b0;
    int prev_h = -1, nrise = 0, hs_low_b = 0, rise0 = 0, rise1 = 0, changes = 0;
    bit reached = 1'b0;
    logic [11:0] rgb00;

    initial begin
        // Reset held with ce_pix high: nothing may advance.
        repeat (3) step(1'b1, 1'b1);
        chk("rst_hcount", hcount, 0);
        chk("rst_vcount", vcount, 0);
        chk("rst_video", {video_r, video_g, video_b}, 0);
        chk("rst_syncs", {hsync_n, vsync_n, csync}, 3'b111);
        chk("rst_frame_start", frame_start, 0);

        // One full frame with ce_pix constantly high.
        for (int i = 1; i <= HT * VT; i++) begin
            step(1'b1, 1'b0);
            if (frame_start) begin fs_cnt++; fs_at = i; end
            if (vcount == 0 && !hsync_n) begin
                hs_low++;
                if (hs_first < 0) hs_first = hcount;
            end
            if (hcount == 1 && !vsync_n) begin
                vs_lines++;
                if (vs_first < 0) vs_first = vcount;
            end
            if (!vsync_n && csync) cs_hi++;
            if (hcount == 11 && vcount == 5) begin
                seen_px = 1'b1;
                chk("pix_10_5_r", video_r, 4'hF);
                chk("pix_10_5_g", video_g, 4'h0);
                chk("pix_10_5_b", video_b, 4'hA);
            end
            if (hcount == 301 && vcount == 5) begin
                seen_blank = 1'b1;
                chk("pix_300_5_blank", {video_r, video_g, video_b}, 0);
            end
        end
        chk("frame_start_count", fs_cnt, 1);
        chk("frame_start_clk", fs_at, HT * VT);
        chk("seen_pix_10_5", seen_px, 1);
        chk("seen_pix_300_5", seen_blank, 1);
        chk("hsync_low_pixels", hs_low, HS);
        chk("hsync_first_hcount", hs_first, HA + HF + 1);
        chk("vsync_low_lines", vs_lines, VS);
        chk("vsync_first_line", vs_first, VA + VF);
        chk("csync_high_in_vsync", cs_hi, CS_HI_EXP);
        step(1'b1, 1'b0);
        chk("wrap_hcount", hcount, 0);
        chk("wrap_vcount", vcount, 0);

        // ce_pix one clock in four.
        for (int i = 0; i < 3300; i++) begin
            step(i % 4 == 0, 1'b0);
            if (nrise == 1 && !hsync_n) hs_low_b++;
            if (nrise == 1 && hcount != prev_h) changes++;
            if (hcount == 4 && prev_h == 3) begin
                if (nrise == 0) rise0 = i;
                else if (nrise == 1) rise1 = i;
                nrise++;
            end
            prev_h = hcount;
        end
        chk("ce4_line_seen", (nrise >= 2), 1);
        chk("ce4_line_period", rise1 - rise0, 4 * HT);
        chk("ce4_hsync_clks", hs_low_b, 4 * HS);
        chk("ce4_hcount_steps", changes, HT);

        // Reset in the middle of a horizontal and vertical sync pulse.
        for (int i = 0; i < 6000 && !reached; i++) begin
            step(1'b1, 1'b0);
            if (mh == 280 && mv == VA + VF) reached = 1'b1;
        end
        chk("reach_mid_sync", reached, 1);
        chk("mid_sync_hsync_low", hsync_n, 0);
        step(1'($urandom_range(0, 1)), 1'b1);
        step(1'b0, 1'b0);
        chk("midrst_hcount", hcount, 0);
        chk("midrst_vcount", vcount, 0);
        chk("midrst_video", {video_r, video_g, video_b}, 0);
        chk("midrst_syncs", {hsync_n, vsync_n, csync}, 3'b111);
        step(1'b1, 1'b0);
        rgb00 = rgb_in;
        step(1'b0, 1'b0);
        chk("first_pixel_00", {video_r, video_g, video_b}, rgb00);
        chk("first_pixel_hcount", hcount, 1);

        // Random pixel enables with rare resets, checked by the model every cycle.
        for (int i = 0; i < 20000; i++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 1999) == 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
